gemac_pfc_ctrl: RTL and testbench

//  Parametrised MAC flow-control engine: per-priority (802.1Qbb PFC) and classic (802.3x) pause handling.
//  Rx side: parsed pause frames load per-class timers; tx MAC sees per-class hold-off, applied only at frame boundaries.

---
 rtl/gemac_pfc_pkg.sv | 20 ++
 rtl/gemac_pause_timer.sv | 40 ++++
 rtl/gemac_pfc_ctrl.sv | 152 +++++++++++++++
 tb/tb_gemac_pfc_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemac_pfc_pkg.sv
// Shared constants, types and helpers for the gemac PFC / 802.3x flow-control engine.
package gemac_pfc_pkg;

    localparam int QUANTA_W = 16;
    localparam int MAX_PRIO = 8;

    localparam logic [15:0] PAUSE_OPC_CLASSIC = 16'h0001;
    localparam logic [15:0] PAUSE_OPC_PFC     = 16'h0101;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } tx_state_t;

    // One pause quantum is 512 bit times on the line.
    function automatic int cyc_per_q(input int bits_per_clk);
        return 512 / bits_per_clk;
    endfunction

endpackage

// File: rtl/gemac_pause_timer.sv
// Per-class pause timer: a quanta counter clocked by a sub-counter that divides clk down to one quantum.
module gemac_pause_timer
    import gemac_pfc_pkg::*;
#(
    parameter int CYC_PER_Q = 64
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [QUANTA_W-1:0] load_value,
    output logic                pending
);

    localparam int              SUB_W   = (CYC_PER_Q > 1) ? $clog2(CYC_PER_Q) : 1;
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(CYC_PER_Q - 1);

    logic [QUANTA_W-1:0] timer_reg;
    logic [SUB_W-1:0]    sub_reg;

    // A load always replaces the running count, even on the cycle it would expire.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_reg <= '0;
            sub_reg   <= '0;
        end else if (load) begin
            timer_reg <= load_value;
            sub_reg   <= SUB_MAX;
        end else if (timer_reg != '0) begin
            if (sub_reg == '0) begin
                timer_reg <= timer_reg - 1'b1;
                sub_reg   <= SUB_MAX;
            end else begin
                sub_reg <= sub_reg - 1'b1;
            end
        end
    end

    assign pending = (timer_reg != '0);

endmodule

// File: rtl/gemac_pfc_ctrl.sv
// MAC flow-control engine: rx pause timers gate per-class transmit, optional tx pause-frame generator.
// Define GEMAC_PFC_XMIT_EN to build the tx-side request FSM; otherwise the request outputs are tied off.
module gemac_pfc_ctrl
    import gemac_pfc_pkg::*;
#(
    parameter int                  NUM_PRIO     = 8,
    parameter int                  BITS_PER_CLK = 8,
    parameter logic [QUANTA_W-1:0] XOFF_QUANTA  = 16'hFFFF,
    parameter int unsigned         REFRESH_CYC  = (XOFF_QUANTA / 2) * cyc_per_q(BITS_PER_CLK)
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx_pause_val,
    input  logic                         rx_pause_pfc,
    input  logic [MAX_PRIO-1:0]          rx_pause_cev,
    input  logic [MAX_PRIO*QUANTA_W-1:0] rx_pause_quanta,
    input  logic [NUM_PRIO-1:0]          pause_respect_en,
    input  logic                         tx_in_frame,
    output logic [NUM_PRIO-1:0]          paused,
    input  logic [NUM_PRIO-1:0]          xoff_req,
    output logic                         pause_req,
    output logic [MAX_PRIO-1:0]          pause_req_cev,
    output logic [MAX_PRIO*QUANTA_W-1:0] pause_req_quanta,
    input  logic                         pause_ack
);

    localparam int CYC_PER_Q = cyc_per_q(BITS_PER_CLK);

    logic [NUM_PRIO-1:0] timer_load;
    logic [NUM_PRIO-1:0] pending;
    logic [QUANTA_W-1:0] load_value [NUM_PRIO];
    logic [NUM_PRIO-1:0] paused_reg;
    logic [NUM_PRIO-1:0] paused_next;

    // Classic pause applies quanta[0] to every class; PFC loads only enabled classes.
    generate
        for (genvar gi = 0; gi < NUM_PRIO; gi++) begin : g_class
            assign timer_load[gi] = rx_pause_val & (~rx_pause_pfc | rx_pause_cev[gi]);
            assign load_value[gi] = rx_pause_pfc ? rx_pause_quanta[QUANTA_W*gi +: QUANTA_W]
                                                 : rx_pause_quanta[QUANTA_W-1:0];

            gemac_pause_timer #(
                .CYC_PER_Q (CYC_PER_Q)
            ) u_timer (
                .clk        (clk),
                .reset      (reset),
                .load       (timer_load[gi]),
                .load_value (load_value[gi]),
                .pending    (pending[gi])
            );
        end
    endgenerate

    // A class may only become paused between frames, but is released immediately.
    assign paused_next = pending & pause_respect_en & (paused_reg | {NUM_PRIO{~tx_in_frame}});

    always_ff @(posedge clk) begin
        if (reset) begin
            paused_reg <= '0;
        end else begin
            paused_reg <= paused_next;
        end
    end

    assign paused = paused_reg;

    logic unused_rx;
    assign unused_rx = &{1'b0, rx_pause_cev, rx_pause_quanta};

`ifdef GEMAC_PFC_XMIT_EN
    tx_state_t                    state_reg, state_next;
    logic [NUM_PRIO-1:0]          snap_reg, snap_next;
    logic [NUM_PRIO-1:0]          xoff_sent_reg, xoff_sent_next;
    logic [31:0]                  refresh_reg, refresh_next;
    logic [MAX_PRIO-1:0]          cev_reg, cev_next;
    logic [MAX_PRIO*QUANTA_W-1:0] quanta_reg, quanta_next;
    logic [MAX_PRIO-1:0]          req_cev;
    logic [MAX_PRIO*QUANTA_W-1:0] req_quanta;

    // Classes that were XOFF but are now released stay in the vector with time 0 (XON).
    generate
        for (genvar gi = 0; gi < MAX_PRIO; gi++) begin : g_req
            if (gi < NUM_PRIO) begin : g_live
                assign req_cev[gi] = xoff_req[gi] | xoff_sent_reg[gi];
                assign req_quanta[QUANTA_W*gi +: QUANTA_W] = xoff_req[gi] ? XOFF_QUANTA : '0;
            end else begin : g_none
                assign req_cev[gi] = 1'b0;
                assign req_quanta[QUANTA_W*gi +: QUANTA_W] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            snap_reg      <= '0;
            xoff_sent_reg <= '0;
            refresh_reg   <= '0;
            cev_reg       <= '0;
            quanta_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            snap_reg      <= snap_next;
            xoff_sent_reg <= xoff_sent_next;
            refresh_reg   <= refresh_next;
            cev_reg       <= cev_next;
            quanta_reg    <= quanta_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        snap_next      = snap_reg;
        xoff_sent_next = xoff_sent_reg;
        cev_next       = cev_reg;
        quanta_next    = quanta_reg;
        refresh_next   = ((xoff_sent_reg != '0) && (refresh_reg != '0)) ? refresh_reg - 32'd1
                                                                        : refresh_reg;
        case (state_reg)
            IDLE: begin
                if ((xoff_req != xoff_sent_reg) ||
                    ((refresh_reg == '0) && (xoff_sent_reg != '0))) begin
                    state_next  = REQ;
                    snap_next   = xoff_req;
                    cev_next    = req_cev;
                    quanta_next = req_quanta;
                end
            end
            REQ: begin
                if (pause_ack) begin
                    state_next     = IDLE;
                    xoff_sent_next = snap_reg;
                    refresh_next   = REFRESH_CYC;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pause_req        = (state_reg == REQ);
    assign pause_req_cev    = cev_reg;
    assign pause_req_quanta = quanta_reg;
`else
    assign pause_req        = 1'b0;
    assign pause_req_cev    = '0;
    assign pause_req_quanta = '0;

    logic unused_xmit;
    assign unused_xmit = &{1'b0, xoff_req, pause_ack, XOFF_QUANTA, REFRESH_CYC};
`endif

endmodule

// File: tb/tb_gemac_pfc_ctrl.sv
// Directed bench for gemac_pfc_ctrl: table of pause-frame loads plus hand-written timing sequences.
module tb_gemac_pfc_ctrl;
    import gemac_pfc_pkg::*;

    localparam int unsigned TB_REFRESH = 100;

    logic         clk = 1'b0;
    logic         reset;
    logic         rx_pause_val;
    logic         rx_pause_pfc;
    logic [7:0]   rx_pause_cev;
    logic [127:0] rx_pause_quanta;
    logic [7:0]   pause_respect_en;
    logic         tx_in_frame;
    logic [7:0]   paused;
    logic [7:0]   xoff_req;
    logic         pause_req;
    logic [7:0]   pause_req_cev;
    logic [127:0] pause_req_quanta;
    logic         pause_ack;

    int errors = 0;
    int checks = 0;

    gemac_pfc_ctrl #(
        .NUM_PRIO     (8),
        .BITS_PER_CLK (8),
        .XOFF_QUANTA  (16'hFFFF),
        .REFRESH_CYC  (TB_REFRESH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_pause_val     (rx_pause_val),
        .rx_pause_pfc     (rx_pause_pfc),
        .rx_pause_cev     (rx_pause_cev),
        .rx_pause_quanta  (rx_pause_quanta),
        .pause_respect_en (pause_respect_en),
        .tx_in_frame      (tx_in_frame),
        .paused           (paused),
        .xoff_req         (xoff_req),
        .pause_req        (pause_req),
        .pause_req_cev    (pause_req_cev),
        .pause_req_quanta (pause_req_quanta),
        .pause_ack        (pause_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        pfc;
        logic [7:0]  cev;
        logic [31:0] q_nib;     // class i quanta in nibble i
        logic [7:0]  respect;
        logic [7:0]  exp_first; // paused one cycle after the load
        logic [31:0] exp_nib;   // quanta each class stays paused for
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] q_from_nib(input logic [31:0] n);
        logic [127:0] q;
        q = '0;
        for (int i = 0; i < 8; i++) q[16*i +: 16] = {12'h000, n[4*i +: 4]};
        return q;
    endfunction

    task automatic send_pause(input logic pfc, input logic [7:0] cev, input logic [31:0] nib);
        rx_pause_pfc    = pfc;
        rx_pause_cev    = cev;
        rx_pause_quanta = q_from_nib(nib);
        rx_pause_val    = 1'b1;
        tick();
        rx_pause_val    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [127:0] act_len, exp_len;
        int           cnt [8];
        int           n, last_high;

        reset = 1'b1;
        rx_pause_val = 1'b0; rx_pause_pfc = 1'b0; rx_pause_cev = '0; rx_pause_quanta = '0;
        pause_respect_en = 8'hFF; tx_in_frame = 1'b0; xoff_req = '0; pause_ack = 1'b0;

        //            pfc   cev    q_nib         respect exp_first exp_nib
        vecs[0] = '{1'b0, 8'h0F, 32'h12121213, 8'hFF, 8'hFF, 32'h33333333};
        vecs[1] = '{1'b1, 8'h05, 32'h00000102, 8'hFF, 8'h05, 32'h00000102};
        vecs[2] = '{1'b1, 8'hFF, 32'h32103210, 8'h0F, 8'h0E, 32'h00003210};
        vecs[3] = '{1'b1, 8'hA0, 32'h21112222, 8'hFF, 8'hA0, 32'h20100000};
        vecs[4] = '{1'b0, 8'hFF, 32'h33333330, 8'hFF, 8'h00, 32'h00000000};
        vecs[5] = '{1'b1, 8'h00, 32'h11111111, 8'hFF, 8'h00, 32'h00000000};
        vecs[6] = '{1'b0, 8'h00, 32'h00000001, 8'h5A, 8'h5A, 32'h01011010};

        tick();
        tick();
        check("reset paused", 128'(paused), 128'h0);
        check("reset pause_req", 128'(pause_req), 128'h0);
        check("reset cev", 128'(pause_req_cev), 128'h0);
        check("reset quanta", pause_req_quanta, 128'h0);
        reset = 1'b0;

        // Table: each load is followed by 200 cycles; count how long each class stays paused.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            pause_respect_en = vecs[v].respect;
            send_pause(vecs[v].pfc, vecs[v].cev, vecs[v].q_nib);
            for (int i = 0; i < 8; i++) cnt[i] = 0;
            for (int k = 1; k <= 200; k++) begin
                tick();
                if (k == 1) check($sformatf("vec%0d first", v), 128'(paused), 128'(vecs[v].exp_first));
                for (int i = 0; i < 8; i++) cnt[i] += int'(paused[i]);
            end
            act_len = '0;
            exp_len = '0;
            for (int i = 0; i < 8; i++) begin
                act_len[16*i +: 16] = 16'(cnt[i]);
                exp_len[16*i +: 16] = 16'(vecs[v].exp_nib[4*i +: 4]) * 16'd64;
            end
            check($sformatf("vec%0d len", v), act_len, exp_len);
            $display("vec %0d pfc=%0b cev=%02h respect=%02h class0 held %0d cycles",
                     v, vecs[v].pfc, vecs[v].cev, vecs[v].respect, cnt[0]);
        end

        // XON for class 0 mid-hold; class 2 keeps its own 64-cycle hold.
        do_reset();
        pause_respect_en = 8'hFF;
        send_pause(1'b1, 8'h05, 32'h00000102);
        for (int k = 1; k <= 49; k++) tick();
        send_pause(1'b1, 8'h01, 32'h00000000);
        check("xon before drop", 128'(paused), 128'h05);
        tick();
        check("xon class0 drop", 128'(paused), 128'h04);
        for (int k = 52; k <= 64; k++) tick();
        check("xon class2 last", 128'(paused), 128'h04);
        tick();
        check("xon class2 drop", 128'(paused), 128'h00);
        $display("seq xon mid-hold done");

        // Pause cannot start mid-frame but is released regardless of tx_in_frame.
        do_reset();
        tx_in_frame = 1'b1;
        send_pause(1'b1, 8'h01, 32'h00000001);
        for (int k = 1; k <= 19; k++) tick();
        check("inframe blocked", 128'(paused), 128'h00);
        tx_in_frame = 1'b0;
        tick();
        check("inframe rise", 128'(paused), 128'h01);
        for (int k = 21; k <= 30; k++) tick();
        tx_in_frame = 1'b1;
        for (int k = 31; k <= 64; k++) tick();
        check("inframe last", 128'(paused), 128'h01);
        tick();
        check("inframe drop", 128'(paused), 128'h00);
        tx_in_frame = 1'b0;
        $display("seq tx_in_frame gating done");

        // Reload on the exact expiry cycle must give one seamless 128-cycle hold.
        do_reset();
        n = 0;
        last_high = 0;
        send_pause(1'b1, 8'h01, 32'h00000001);
        for (int k = 1; k <= 130; k++) begin
            if (k == 64) send_pause(1'b1, 8'h01, 32'h00000001);
            else tick();
            if (paused[0]) begin
                n++;
                last_high = k;
            end
        end
        check("reload count", 128'(n), 128'd128);
        check("reload last", 128'(last_high), 128'd128);
        $display("seq reload at expiry: held %0d cycles", n);

        // Respect mask drops and restores paused with one cycle of latency.
        do_reset();
        send_pause(1'b0, 8'h00, 32'h00000002);
        for (int k = 1; k <= 10; k++) tick();
        check("respect on", 128'(paused), 128'hFF);
        pause_respect_en = 8'hF0;
        tick();
        check("respect mask", 128'(paused), 128'hF0);
        for (int k = 12; k <= 20; k++) tick();
        pause_respect_en = 8'hFF;
        tick();
        check("respect restore", 128'(paused), 128'hFF);

        // Reset in the middle of a hold clears everything.
        reset = 1'b1;
        tick();
        check("midhold reset", 128'(paused), 128'h00);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("after reset", 128'(paused), 128'h00);
        $display("seq respect mask and reset done");

`ifdef GEMAC_PFC_XMIT_EN
        do_reset();
        xoff_req = 8'h02;
        tick();
        check("xoff req", 128'(pause_req), 128'h1);
        check("xoff cev", 128'(pause_req_cev), 128'h02);
        check("xoff quanta", pause_req_quanta, {96'h0, 16'hFFFF, 16'h0000});
        for (int k = 0; k < 3; k++) tick();
        check("xoff hold", 128'(pause_req_cev), 128'h02);
        pause_ack = 1'b1;
        tick();
        pause_ack = 1'b0;
        check("xoff acked", 128'(pause_req), 128'h0);
        n = 0;
        while (!pause_req && n < 500) begin
            tick();
            n++;
        end
        check("refresh delay", 128'(n), 128'(TB_REFRESH + 1));
        check("refresh quanta", pause_req_quanta, {96'h0, 16'hFFFF, 16'h0000});
        pause_ack = 1'b1;
        tick();
        pause_ack = 1'b0;
        xoff_req = 8'h00;
        tick();
        check("xon req", 128'(pause_req), 128'h1);
        check("xon cev", 128'(pause_req_cev), 128'h02);
        check("xon quanta", pause_req_quanta, 128'h0);
        pause_ack = 1'b1;
        tick();
        pause_ack = 1'b0;
        n = 0;
        for (int k = 0; k < 3 * TB_REFRESH; k++) begin
            tick();
            n += int'(pause_req);
        end
        check("no refresh after xon", 128'(n), 128'h0);
        $display("seq xoff/refresh/xon done");

        xoff_req = 8'h01;
        tick();
        check("req before reset", 128'(pause_req), 128'h1);
        reset = 1'b1;
        xoff_req = 8'h00;
        tick();
        check("reset drops req", 128'(pause_req), 128'h0);
        check("reset clears cev", 128'(pause_req_cev), 128'h00);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("sent cleared", 128'(pause_req), 128'h0);
        $display("seq reset in REQ done");
`else
        do_reset();
        xoff_req = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            pause_ack = k[0];
            tick();
        end
        pause_ack = 1'b0;
        check("tied req", 128'(pause_req), 128'h0);
        check("tied cev", 128'(pause_req_cev), 128'h0);
        check("tied quanta", pause_req_quanta, 128'h0);
        xoff_req = 8'h00;
        $display("seq tx outputs tied off done");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
